seg_multi_cycle_adder: RTL and testbench
========================================

// Module: seg_multi_cycle_adder
// PURPOSE
//   Parametrised iterative adder/subtractor for the measure unit. Splits a WIDTH-bit
//   add into WIDTH/SEG_W segments, one segment per clock, so wide sums meet timing.
//   Adds a ready/valid input handshake, subtract mode, carry-in, carry-out and
//   signed overflow. Used for timestamp and accumulator arithmetic.
// PARAMETERS
//   WIDTH   32  operand/result width in bits
//   SEG_W   16  bits added per cycle; WIDTH % SEG_W != 0 -> elaboration $error
//   NSEG    WIDTH/SEG_W  localparam, number of segments (>= 1)
// PORTS
//   clk_i    in   1       clock, all logic on posedge
//   rst_i    in   1       synchronous reset, active-high
//   a_i      in   WIDTH   operand A
//   b_i      in   WIDTH   operand B
//   sub_i    in   1       1: A - B, 0: A + B
//   cin_i    in   1       carry-in, add mode only; ignored when sub_i=1
//   valid_i  in   1       operands valid
//   ready_o  out  1       block can accept; transfer when valid_i && ready_o
//   valid_o  out  1       one-cycle pulse: res_o/cout_o/ovf_o are new
//   res_o    out  WIDTH   result, modulo 2^WIDTH
//   cout_o   out  1       carry out of bit WIDTH-1; in sub mode 1 = no borrow
//   ovf_o    out  1       two's-complement signed overflow
// BEHAVIOUR
//   Reset (rst_i=1 at posedge): state=IDLE, seg_cnt=0, valid_o=0, res_o=0, cout_o=0,
//     ovf_o=0. ready_o is forced to 0 while rst_i=1.
//   ready_o = (state==IDLE) && !rst_i. Combinational from state only, not from valid_i.
//   FSM states:
//     IDLE: on accept, register a_i; register b_i, or ~b_i if sub_i=1; register the
//       carry as cin_i, or 1 if sub_i=1; set seg_cnt=0; go to BUSY.
//     BUSY: each cycle {c, res[seg_cnt*SEG_W +: SEG_W]} <= a_seg + b_seg + c, then
//       seg_cnt++. After segment NSEG-1: go to IDLE, assert valid_o for one cycle,
//       update cout_o = final carry, ovf_o = (a_msb == b'_msb) && (res_msb != a_msb),
//       where b' is the registered, possibly inverted, B.
//   Latency: accept at edge k -> valid_o high in the cycle after edge k+NSEG.
//     Throughput: one op per NSEG cycles.
//   Back-to-back: ready_o is high in the same cycle valid_o is high, so a new accept is
//     legal then. The new op does not disturb res_o until its own completion.
//   res_o, cout_o and ovf_o hold their last completed value between completions.
//     Partial segments are written to an internal register, not to res_o.
//   valid_i while BUSY: ignored, no latch, no error. Operands must be re-presented
//     until accepted.
//   Input changes after accept have no effect; operands are captured at accept.
//   Reset mid-BUSY: operation is aborted, no valid_o pulse, outputs return to reset
//     values.
//   NSEG=1: single add, valid_o one cycle after accept.
//   Wrap-around: sums of 2^WIDTH or more wrap, with cout_o=1.
// TESTING (WIDTH=32, SEG_W=8 unless noted)
//   1. Reset, then A=0x0000_00FF, B=0x0000_0001, add ->
//      valid_o 4 cycles after accept, res=0x0000_0100, cout=0, ovf=0.
//   2. Carry chain: A=0xFFFF_FFFF, B=0x1, add -> res=0, cout=1, ovf=0.
//      Also A=0x7FFF_FFFF, B=1 -> res=0x8000_0000, ovf=1.
//   3. Subtract: A=5, B=7, sub -> res=0xFFFF_FFFE, cout=0.
//      Also A=0x8000_0000, B=1, sub -> res=0x7FFF_FFFF, ovf=1.
//   4. Handshake: hold valid_i high with new operands during BUSY -> not accepted.
//      Back-to-back accept on the valid_o cycle -> two results spaced 4 cycles apart.
//      res_o stable between pulses.
//   5. Reset mid-op: rst_i pulse at BUSY segment 2 -> no valid_o, res_o=0, ready_o=1
//      the cycle after reset deasserts.
//   6. Param sweep SEG_W in {32,16,8,4}: 1000 random A/B/sub/cin ops checked against
//      a reference model. Latency must equal 32/SEG_W.

Source files
------------

// File: rtl/seg_multi_cycle_adder.sv
// Iterative WIDTH-bit adder/subtractor: one SEG_W-bit segment per clock,
// ripple carry held in a register between segments. Ready/valid input
// handshake, subtract mode, carry-in, carry-out and signed overflow.
module seg_multi_cycle_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             cin_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] res_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int NSEG  = WIDTH / SEG_W;
    localparam int CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NSEG - 1);

    // A width that is not a whole number of segments would leave high bits unadded.
    if ((WIDTH % SEG_W) != 0 || NSEG < 1) begin : g_bad_seg_w
        $error("seg_multi_cycle_adder: WIDTH must be a non-zero multiple of SEG_W");
    end

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_seg_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;      // B, already inverted in subtract mode
    logic             r_carry;  // ripple carry between segments
    logic [WIDTH-1:0] r_acc;    // partial result, kept apart from res_o
    logic             r_valid;
    logic [WIDTH-1:0] r_res;
    logic             r_cout;
    logic             r_ovf;

    logic             w_ready;
    logic             w_accept;
    logic             w_last;
    logic [IDX_W-1:0] w_seg_base;
    logic [SEG_W-1:0] w_a_seg;
    logic [SEG_W-1:0] w_b_seg;
    logic [SEG_W:0]   w_seg_sum;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_ovf;

    assign w_ready  = (r_state == S_IDLE) && !rst_i;
    assign w_accept = valid_i && w_ready;
    assign w_last   = (r_seg_cnt == LAST_SEG);

    // Current segment slice, its sum with the running carry, and the merged result.
    always_comb begin
        w_seg_base = IDX_W'(32'(r_seg_cnt) * 32'(SEG_W));
        w_a_seg    = r_a[w_seg_base +: SEG_W];
        w_b_seg    = r_b[w_seg_base +: SEG_W];
        w_seg_sum  = {1'b0, w_a_seg} + {1'b0, w_b_seg} + {{SEG_W{1'b0}}, r_carry};
        w_acc_next = r_acc;
        w_acc_next[w_seg_base +: SEG_W] = w_seg_sum[SEG_W-1:0];
        // Signed overflow: operands share a sign that the result does not.
        w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
    end

    // Control FSM plus the visible result registers, which reset to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_seg_cnt <= '0;
            r_valid   <= 1'b0;
            r_res     <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_BUSY;
                        r_seg_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    r_seg_cnt <= r_seg_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state   <= S_IDLE;
                        r_seg_cnt <= '0;
                        r_valid   <= 1'b1;
                        r_res     <= w_acc_next;
                        r_cout    <= w_seg_sum[SEG_W];
                        r_ovf     <= w_ovf;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_seg_cnt <= '0;
                end
            endcase
        end
    end

    // Operand capture at accept, then segment-by-segment accumulation while busy.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_a     <= a_i;
            r_b     <= sub_i ? ~b_i : b_i;
            r_carry <= sub_i ? 1'b1 : cin_i;
            r_acc   <= '0;
        end else if (r_state == S_BUSY) begin
            r_acc   <= w_acc_next;
            r_carry <= w_seg_sum[SEG_W];
        end
    end

    assign ready_o = w_ready;
    assign valid_o = r_valid;
    assign res_o   = r_res;
    assign cout_o  = r_cout;
    assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_seg_multi_cycle_adder.sv
// Bench for seg_multi_cycle_adder: four instances with WIDTH=32 and
// SEG_W = 32,16,8,4; directed scenarios run on the SEG_W=8 instance.
module tb_seg_multi_cycle_adder;

    localparam int NI   = 4;
    localparam int MAIN = 2;   // SEG_W = 8

    typedef struct packed {
        logic [31:0] res;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        sub, cin;
    logic        vin  [NI];
    logic        rdy  [NI];
    logic        vo   [NI];
    logic [31:0] res  [NI];
    logic        cout [NI];
    logic        ovf  [NI];

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        seg_multi_cycle_adder #(.WIDTH(32), .SEG_W(32 >> gi)) u_dut (
            .clk_i   (clk),
            .rst_i   (rst),
            .a_i     (a),
            .b_i     (b),
            .sub_i   (sub),
            .cin_i   (cin),
            .valid_i (vin[gi]),
            .ready_o (rdy[gi]),
            .valid_o (vo[gi]),
            .res_o   (res[gi]),
            .cout_o  (cout[gi]),
            .ovf_o   (ovf[gi])
        );
    end

    // Reference: full-width add of A and (possibly inverted) B with carry.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic ms, input logic mc);
        exp_t        e;
        logic [31:0] bb;
        logic [32:0] full;
        bb     = ms ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, bb} + {32'd0, (ms ? 1'b1 : mc)};
        e.res  = full[31:0];
        e.cout = full[32];
        e.ovf  = (ma[31] == bb[31]) && (full[31] != ma[31]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for ready, present one operation for a single cycle, queue its expectation.
    task automatic issue(input int idx, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic ts, input logic tc, input exp_t e);
        int n = 0;
        while (!rdy[idx] && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (rdy[idx] !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait inst=%0d ready=%b required 1", idx, rdy[idx]);
        end
        a = ta; b = tb_v; sub = ts; cin = tc;
        vin[idx] = 1'b1;
        sb_q.push_back(e);
        tick();
        vin[idx] = 1'b0;
    endtask

    // Count cycles until valid_o; lat is edges since the accept edge.
    task automatic wait_out(input int idx, output int lat, output bit seen);
        lat = 0;
        while (!vo[idx] && lat < 50) begin
            tick();
            lat++;
        end
        seen = vo[idx];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < NI; i++) vin[i] = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (rdy[i] !== 1'b0 || vo[i] !== 1'b0 || res[i] !== 32'd0 ||
                cout[i] !== 1'b0 || ovf[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst=%0d rdy=%b vo=%b res=%h cout=%b ovf=%b required 0 0 0 0 0",
                         i, rdy[i], vo[i], res[i], cout[i], ovf[i]);
            end
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (rdy[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release_ready inst=%0d got=%b required 1", i, rdy[i]);
            end
        end
    endtask

    task automatic test_arith();
        logic [31:0] ta [9] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h5, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'h5, 32'h1234_5678, 32'h7};
        logic [31:0] tb_v [9] = '{32'h1, 32'h1, 32'h1, 32'h7, 32'h1,
                                  32'h0, 32'h7, 32'h0F0F_0F0F, 32'h5};
        logic        ts [9] = '{0, 0, 0, 1, 1, 0, 1, 0, 1};
        logic        tc [9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
        logic [31:0] er [9] = '{32'h0000_0100, 32'h0, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF,
                                32'h0, 32'hFFFF_FFFE, 32'h2143_6587, 32'h2};
        logic        ec [9] = '{0, 1, 0, 0, 1, 1, 0, 0, 1};
        logic        eo [9] = '{0, 0, 1, 0, 1, 0, 0, 0, 0};
        exp_t e, got;
        int   lat;
        bit   seen;
        for (int i = 0; i < 9; i++) begin
            e.res = er[i]; e.cout = ec[i]; e.ovf = eo[i];
            issue(MAIN, ta[i], tb_v[i], ts[i], tc[i], e);
            wait_out(MAIN, lat, seen);
            e = sb_q.pop_front();
            got.res = res[MAIN]; got.cout = cout[MAIN]; got.ovf = ovf[MAIN];
            checks++;
            if (!seen || lat != 4) begin
                errors++;
                $display("FAIL arith_latency op=%0d seen=%b lat=%0d required 4", i, seen, lat);
            end
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL arith_result op=%0d res=%h cout=%b ovf=%b required res=%h cout=%b ovf=%b",
                         i, got.res, got.cout, got.ovf, e.res, e.cout, e.ovf);
            end
            tick();
        end
    endtask

    task automatic test_handshake();
        exp_t e;
        int   lat, pulses;
        bit   seen;
        e.res = 32'h3; e.cout = 1'b0; e.ovf = 1'b0;
        issue(MAIN, 32'h1, 32'h2, 1'b0, 1'b0, e);
        // New operands offered while busy must be ignored, including the captured ones.
        a = 32'h100; b = 32'h200; sub = 1'b1; cin = 1'b1;
        vin[MAIN] = 1'b1;
        tick(); tick(); tick();
        vin[MAIN] = 1'b0;
        wait_out(MAIN, lat, seen);
        e = sb_q.pop_front();
        checks++;
        if (!seen || lat != 1) begin
            errors++;
            $display("FAIL hs_latency seen=%b lat=%0d required 4", seen, lat + 3);
        end
        checks++;
        if (res[MAIN] !== e.res || cout[MAIN] !== e.cout || ovf[MAIN] !== e.ovf) begin
            errors++;
            $display("FAIL hs_result res=%h cout=%b ovf=%b required res=%h cout=%b ovf=%b",
                     res[MAIN], cout[MAIN], ovf[MAIN], e.res, e.cout, e.ovf);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (vo[MAIN] === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || rdy[MAIN] !== 1'b1) begin
            errors++;
            $display("FAIL hs_busy_ignored pulses=%0d ready=%b required 0 1", pulses, rdy[MAIN]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2, e;
        int   lat;
        bit   seen;
        e1.res = 32'h0001_0000; e1.cout = 1'b0; e1.ovf = 1'b0;
        e2.res = 32'hFFFF_FFFE; e2.cout = 1'b1; e2.ovf = 1'b0;
        issue(MAIN, 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, e1);
        wait_out(MAIN, lat, seen);
        e = sb_q.pop_front();
        checks++;
        if (!seen || res[MAIN] !== e.res || cout[MAIN] !== e.cout || ovf[MAIN] !== e.ovf) begin
            errors++;
            $display("FAIL b2b_first seen=%b res=%h cout=%b ovf=%b required res=%h cout=%b ovf=%b",
                     seen, res[MAIN], cout[MAIN], ovf[MAIN], e.res, e.cout, e.ovf);
        end
        checks++;
        if (rdy[MAIN] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_with_valid got=%b required 1", rdy[MAIN]);
        end
        issue(MAIN, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, e2);
        lat = 0;
        while (!vo[MAIN] && lat < 50) begin
            checks++;
            if (res[MAIN] !== 32'h0001_0000) begin
                errors++;
                $display("FAIL b2b_hold res=%h required 00010000", res[MAIN]);
            end
            tick();
            lat++;
        end
        e = sb_q.pop_front();
        checks++;
        if (vo[MAIN] !== 1'b1 || lat != 4) begin
            errors++;
            $display("FAIL b2b_second_latency seen=%b lat=%0d required 4", vo[MAIN], lat);
        end
        checks++;
        if (res[MAIN] !== e.res || cout[MAIN] !== e.cout || ovf[MAIN] !== e.ovf) begin
            errors++;
            $display("FAIL b2b_second res=%h cout=%b ovf=%b required res=%h cout=%b ovf=%b",
                     res[MAIN], cout[MAIN], ovf[MAIN], e.res, e.cout, e.ovf);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        int   pulses;
        e.res = 32'h7; e.cout = 1'b0; e.ovf = 1'b0;
        issue(MAIN, 32'h3, 32'h4, 1'b0, 1'b0, e);
        tick(); tick();
        rst = 1'b1;
        tick();
        void'(sb_q.pop_back());
        checks++;
        if (vo[MAIN] !== 1'b0 || res[MAIN] !== 32'd0 || cout[MAIN] !== 1'b0 ||
            ovf[MAIN] !== 1'b0 || rdy[MAIN] !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset vo=%b res=%h cout=%b ovf=%b rdy=%b required 0 0 0 0 0",
                     vo[MAIN], res[MAIN], cout[MAIN], ovf[MAIN], rdy[MAIN]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rdy[MAIN] !== 1'b1) begin
            errors++;
            $display("FAIL midop_ready_after got=%b required 1", rdy[MAIN]);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (vo[MAIN] === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || res[MAIN] !== 32'd0) begin
            errors++;
            $display("FAIL midop_no_pulse pulses=%0d res=%h required 0 0", pulses, res[MAIN]);
        end
    endtask

    task automatic test_param_sweep();
        logic [31:0] ra, rb;
        logic        rs, rc;
        exp_t        e;
        int          lat;
        bit          seen;
        for (int idx = 0; idx < NI; idx++) begin
            for (int n = 0; n < 1000; n++) begin
                ra = $urandom();
                rb = $urandom();
                rs = 1'($urandom_range(0, 1));
                rc = 1'($urandom_range(0, 1));
                if (n % 8 == 0) ra = 32'hFFFF_FFFF;
                if (n % 8 == 1) rb = 32'h8000_0000;
                if (n % 8 == 2) begin ra = 32'h7FFF_FFFF; rb = 32'h0; end
                issue(idx, ra, rb, rs, rc, model(ra, rb, rs, rc));
                wait_out(idx, lat, seen);
                e = sb_q.pop_front();
                checks++;
                if (!seen || lat != (1 << idx)) begin
                    errors++;
                    $display("FAIL sweep_latency seg_w=%0d op=%0d seen=%b lat=%0d required %0d",
                             32 >> idx, n, seen, lat, 1 << idx);
                end
                checks++;
                if (res[idx] !== e.res || cout[idx] !== e.cout || ovf[idx] !== e.ovf) begin
                    errors++;
                    $display("FAIL sweep_result seg_w=%0d a=%h b=%h sub=%b cin=%b res=%h cout=%b ovf=%b required res=%h cout=%b ovf=%b",
                             32 >> idx, ra, rb, rs, rc, res[idx], cout[idx], ovf[idx],
                             e.res, e.cout, e.ovf);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_handshake();
        test_back_to_back();
        test_reset_mid_op();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
